// File: rtl/mult_issue_buffer.sv
// Operand issue / product capture around a fixed-latency pipelined multiplier.
// Optional: define MULT_ISSUE_BYPASS_EN to forward a product straight to out_* when the FIFO is empty.
module mult_issue_buffer #(
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_p,
    output logic [TAG_W-1:0] out_tag
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]                   mul_a_q, mul_a_d;
    logic [31:0]                   mul_b_q, mul_b_d;
    logic [LATENCY:0]              sr_valid_q, sr_valid_d;
    logic [LATENCY:0][TAG_W-1:0]   sr_tag_q, sr_tag_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                 occ_q, occ_d;

    logic [63:0]      mem_p   [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];

    logic             accept, pop, fifo_wr, fifo_rd;
    logic             fifo_empty, fifo_full;
    logic             last_valid;
    logic [TAG_W-1:0] last_tag;

    assign in_ready   = (occ_q < PW'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign last_valid = sr_valid_q[LATENCY];
    assign last_tag   = sr_tag_q[LATENCY];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

`ifdef MULT_ISSUE_BYPASS_EN
    // An empty FIFO lets the capture-cycle product go straight out; it is
    // only stored if the consumer does not take it this cycle.
    always_comb begin
        out_valid = !fifo_empty || last_valid;
        out_p     = '0;
        out_tag   = '0;
        if (!fifo_empty) begin
            out_p   = mem_p[rd_ptr_q[AW-1:0]];
            out_tag = mem_tag[rd_ptr_q[AW-1:0]];
        end else if (last_valid) begin
            out_p   = mul_p;
            out_tag = last_tag;
        end
        fifo_wr = last_valid && !(fifo_empty && out_ready) && !fifo_full;
        fifo_rd = !fifo_empty && out_ready;
    end
`else
    always_comb begin
        out_valid = !fifo_empty;
        out_p     = '0;
        out_tag   = '0;
        if (!fifo_empty) begin
            out_p   = mem_p[rd_ptr_q[AW-1:0]];
            out_tag = mem_tag[rd_ptr_q[AW-1:0]];
        end
        fifo_wr = last_valid && !fifo_full;
        fifo_rd = !fifo_empty && out_ready;
    end
`endif

    assign pop = out_valid && out_ready;

    always_comb begin
        mul_a_d    = accept ? in_a : mul_a_q;
        mul_b_d    = accept ? in_b : mul_b_q;
        sr_valid_d = {sr_valid_q[LATENCY-1:0], accept};
        sr_tag_d   = {sr_tag_q[LATENCY-1:0], in_tag};
        wr_ptr_d   = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Credits cover in-flight plus buffered ops, so the FIFO cannot overflow.
        occ_d = occ_q;
        if (accept && !pop)
            occ_d = occ_q + 1'b1;
        else if (!accept && pop)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            sr_valid_q <= '0;
            sr_tag_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            sr_valid_q <= sr_valid_d;
            sr_tag_q   <= sr_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr && !sync_reset) begin
            mem_p[wr_ptr_q[AW-1:0]]   <= mul_p;
            mem_tag[wr_ptr_q[AW-1:0]] <= last_tag;
        end
    end
endmodule

// File: tb/tb_mult_issue_buffer.sv
// Randomized bench for mult_issue_buffer with a queue-based reference model and a behavioural multiplier pipe.
module tb_mult_issue_buffer;
    localparam int L  = 8;
    localparam int D  = 4;
    localparam int TW = 4;
`ifdef MULT_ISSUE_BYPASS_EN
    localparam int VIS = L;
`else
    localparam int VIS = L + 1;
`endif

    logic          clk = 1'b0;
    logic          sync_reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_a, in_b, mul_a, mul_b;
    logic [TW-1:0] in_tag, out_tag;
    logic [63:0]   mul_p, out_p;

    mult_issue_buffer #(.LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: L register stages from mul_a/mul_b to mul_p.
    logic [63:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= 64'(mul_a) * 64'(mul_b);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[L-1];

    typedef struct {
        logic [63:0]   p;
        logic [TW-1:0] tag;
        int            acc;
    } op_t;

    op_t         q[$];
    int          cyc = 0;
    logic [31:0] last_a = '0, last_b = '0;
    int          n_checks = 0, n_fail = 0, n_acc_obs = 0;
    logic [63:0] seen[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_valid();
        return (q.size() > 0) && (cyc >= q[0].acc + VIS);
    endfunction

    // One clock: drive inputs, update the model at the edge, check at the falling edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] t, input logic r, input logic rst);
        bit  acc, pop;
        op_t o;
        in_valid = v; in_a = a; in_b = b; in_tag = t; out_ready = r; sync_reset = rst;
        acc = v && (q.size() < D) && !rst;
        pop = m_valid() && r && !rst;
        if (v && in_ready && !rst) n_acc_obs++;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            last_a = '0;
            last_b = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                o.p = 64'(a) * 64'(b); o.tag = t; o.acc = cyc;
                q.push_back(o);
                last_a = a;
                last_b = b;
            end
        end
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(q.size() < D));
        chk("out_valid", 64'(out_valid), 64'(m_valid()));
        if (m_valid()) begin
            chk("out_p", out_p, q[0].p);
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
        chk("mul_a", 64'(mul_a), 64'(last_a));
        chk("mul_b", 64'(mul_b), 64'(last_b));
    endtask

    task automatic idle(input logic r);
        step(1'b0, '0, '0, '0, r, 1'b0);
    endtask

    initial begin
        int first_i;
        in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0; sync_reset = 1;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_out_p", out_p, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        idle(1);

        // Single op with latency measurement.
        step(1, 32'd3, 32'd5, 4'd2, 1, 0);
        first_i = -1;
        for (int i = 1; i <= 14; i++) begin
            idle(1);
            if (out_valid && first_i < 0) begin
                first_i = i;
                chk("single_p", out_p, 64'd15);
                chk("single_tag", 64'(out_tag), 64'd2);
            end
        end
        chk("single_latency", 64'(first_i), 64'(VIS));

        // Extreme operands.
        seen.delete();
        step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1, 0);
        step(1, 32'h0, 32'hFFFF_FFFF, 4'd3, 1, 0);
        step(1, 32'h1, 32'h8000_0000, 4'd5, 1, 0);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            if (out_valid) seen.push_back(out_p);
        end
        chk("ext_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("ext_max", seen[0], 64'hFFFF_FFFE_0000_0001);
            chk("ext_zero", seen[1], 64'd0);
            chk("ext_msb", seen[2], 64'h0000_0000_8000_0000);
        end

        // Backpressure: credit limit holds accepts to FIFO depth.
        n_acc_obs = 0;
        for (int i = 0; i < 16; i++)
            step(1, $urandom, $urandom, 4'($urandom), 0, 0);
        chk("bp_accepts", 64'(n_acc_obs), 64'(D));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        n_acc_obs = 0;
        step(1, 32'd11, 32'd13, 4'd7, 1, 0);
        chk("full_no_accept", 64'(n_acc_obs), 64'd0);
        step(1, 32'd17, 32'd19, 4'd9, 1, 0);
        chk("occ3_accept", 64'(n_acc_obs), 64'd1);
        for (int i = 0; i < 20; i++) idle(1);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 9) < 6, 0);
        for (int i = 0; i < 20; i++) idle(1);

        // Reset mid-flight discards everything.
        step(1, 32'd21, 32'd2, 4'd1, 0, 0);
        step(1, 32'd22, 32'd2, 4'd2, 0, 0);
        step(1, 32'd23, 32'd2, 4'd3, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 0, 1);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 20; i++) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
